// File: rtl/instr_cache_if.sv
// Instruction cache bus: two lookup ports, flush, and the refill channel.
// Signal names are written from the cache's point of view (i_ = into cache).
interface instr_cache_if #(
  parameter int XLEN = 32
);
  logic [1:0]           i_read;
  logic [1:0][XLEN-1:0] i_req_address;
  logic                 i_flush;
  logic [1:0]           o_hit;
  logic [1:0][31:0]     o_data;
  logic [1:0][XLEN-1:0] o_resp_address;
  logic                 o_mem_read;
  logic [XLEN-1:0]      o_mem_address;
  logic                 i_mem_ready;
  logic [31:0]          i_mem_data;

  modport slave (
    input  i_read, i_req_address, i_flush, i_mem_ready, i_mem_data,
    output o_hit, o_data, o_resp_address, o_mem_read, o_mem_address
  );

  modport master (
    output i_read, i_req_address, i_flush, i_mem_ready, i_mem_data,
    input  o_hit, o_data, o_resp_address, o_mem_read, o_mem_address
  );
endinterface

// File: rtl/instr_cache.sv
// Dual-port direct-mapped instruction cache with a single line-refill engine.
// Lookups take one cycle; misses are refilled beat by beat into a line buffer
// and committed in one cycle. A second-port miss can be queued as pending.
// SETS and LINE_WORDS must be powers of two, LINE_WORDS >= 2.
module instr_cache #(
  parameter int XLEN       = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  instr_cache_if.slave bus
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int OB = WB + 2;
  localparam int TB = XLEN - OB - IB;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, COMMIT = 2'd2} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SETS-1:0]      r_valid;
  logic [TB-1:0]        r_tag  [SETS];
  logic [31:0]          r_line [SETS][LINE_WORDS];
  logic [31:0]          r_buf  [LINE_WORDS];
  logic [XLEN-1:0]      r_fill_base;
  logic [XLEN-1:0]      r_pend_base;
  logic                 r_pend_valid;
  logic                 r_flushed;
  logic [WB-1:0]        r_beat;
  logic                 r_mem_read;
  logic [XLEN-1:0]      r_mem_address;
  logic [1:0]           r_hit;
  logic [1:0][31:0]     r_data;
  logic [1:0][XLEN-1:0] r_resp;

  logic [1:0][IB-1:0]   w_idx;
  logic [1:0][TB-1:0]   w_tag;
  logic [1:0][WB-1:0]   w_word;
  logic [1:0][XLEN-1:0] w_base;
  logic [1:0]           w_match;
  logic [1:0]           w_hit;
  logic [1:0]           w_miss;
  logic                 w_last;
  logic                 w_start_pend;
  logic [IB-1:0]        w_fill_idx;
  logic                 w_unused;

  // Byte offset within a word is irrelevant to an instruction fetch.
  assign w_unused = ^{bus.i_req_address[0][1:0], bus.i_req_address[1][1:0]};

  assign w_fill_idx   = r_fill_base[OB +: IB];
  assign w_last       = bus.i_mem_ready && (r_beat == WB'(LINE_WORDS - 1));
  assign w_start_pend = r_pend_valid && !r_flushed && !bus.i_flush &&
                        (r_pend_base != r_fill_base);

  // Per-port address split and tag compare.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_idx[i]   = bus.i_req_address[i][OB +: IB];
      w_tag[i]   = bus.i_req_address[i][XLEN-1 -: TB];
      w_word[i]  = bus.i_req_address[i][2 +: WB];
      w_base[i]  = {bus.i_req_address[i][XLEN-1:OB], {OB{1'b0}}};
      w_match[i] = r_valid[w_idx[i]] && (r_tag[w_idx[i]] == w_tag[i]);
      w_hit[i]   = bus.i_read[i] && (r_state == IDLE) && w_match[i] && !bus.i_flush;
      w_miss[i]  = bus.i_read[i] && (r_state == IDLE) && !w_match[i];
    end
  end

  // Next-state logic of the refill FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_miss[0] || w_miss[1]) w_state_nxt = FILL;
        else                        w_state_nxt = IDLE;
      end
      FILL: begin
        if (w_last) w_state_nxt = COMMIT;
        else        w_state_nxt = FILL;
      end
      COMMIT: begin
        if (w_start_pend) w_state_nxt = FILL;
        else              w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Refill control: line base, beat counter, pending miss, memory request.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_valid       <= '0;
      r_beat        <= '0;
      r_pend_valid  <= 1'b0;
      r_pend_base   <= '0;
      r_fill_base   <= '0;
      r_flushed     <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_address <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss[0]) begin
            r_fill_base   <= w_base[0];
            r_mem_address <= w_base[0];
            r_pend_valid  <= w_miss[1] && (w_base[1] != w_base[0]);
            r_pend_base   <= w_base[1];
            r_mem_read    <= 1'b1;
            r_beat        <= '0;
            r_flushed     <= 1'b0;
          end else if (w_miss[1]) begin
            r_fill_base   <= w_base[1];
            r_mem_address <= w_base[1];
            r_pend_valid  <= 1'b0;
            r_mem_read    <= 1'b1;
            r_beat        <= '0;
            r_flushed     <= 1'b0;
          end else begin
            r_mem_read    <= 1'b0;
          end
        end
        FILL: begin
          if (bus.i_mem_ready) begin
            r_beat        <= r_beat + WB'(1);
            // Offset field wraps on its own, so the index never sees a carry.
            r_mem_address <= {r_fill_base[XLEN-1:OB], r_beat + WB'(1), 2'b00};
            r_mem_read    <= !w_last;
          end else begin
            r_mem_read    <= 1'b1;
          end
          // A flush during refill poisons this line and drops the queued miss.
          if (bus.i_flush) begin
            r_flushed    <= 1'b1;
            r_pend_valid <= 1'b0;
          end else begin
            r_flushed    <= r_flushed;
          end
        end
        COMMIT: begin
          r_pend_valid <= 1'b0;
          if (w_start_pend) begin
            r_fill_base   <= r_pend_base;
            r_mem_address <= r_pend_base;
            r_mem_read    <= 1'b1;
            r_beat        <= '0;
            r_flushed     <= 1'b0;
          end else begin
            r_mem_read    <= 1'b0;
          end
        end
        default: r_mem_read <= 1'b0;
      endcase

      if (bus.i_flush)                           r_valid <= '0;
      else if (r_state == COMMIT && !r_flushed)  r_valid[w_fill_idx] <= 1'b1;
      else                                       r_valid <= r_valid;
    end
  end

  // Line buffer capture and line/tag commit; validity is tracked separately.
  always_ff @(posedge i_clock) begin
    if (i_reset && r_state == FILL && bus.i_mem_ready) begin
      r_buf[r_beat] <= bus.i_mem_data;
    end else if (i_reset && r_state == COMMIT) begin
      for (int w = 0; w < LINE_WORDS; w++) r_line[w_fill_idx][w] <= r_buf[w];
      r_tag[w_fill_idx] <= r_fill_base[XLEN-1 -: TB];
    end else begin
      r_tag[w_fill_idx] <= r_tag[w_fill_idx];
    end
  end

  // Registered lookup responses; data and address hold on a non-hit.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_hit  <= 2'b00;
      r_data <= '0;
      r_resp <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_hit[i]) begin
          r_hit[i]  <= 1'b1;
          r_data[i] <= r_line[w_idx[i]][w_word[i]];
          r_resp[i] <= bus.i_req_address[i];
        end else begin
          r_hit[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.o_hit          = r_hit;
  assign bus.o_data         = r_data;
  assign bus.o_resp_address = r_resp;
  assign bus.o_mem_read     = r_mem_read;
  assign bus.o_mem_address  = r_mem_address;
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: refills, dual-port hits, pending miss,
// stalled memory, flush during refill and reset during refill.
module tb_instr_cache;
  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  instr_cache_if #(.XLEN(XLEN)) bus ();

  // 64 sets so that 0x100/0x110/0x200/0x300 map to distinct lines.
  instr_cache #(.XLEN(XLEN), .SETS(64), .LINE_WORDS(4)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle and sample just after the edge; memory model follows address.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_mem_data = mem_word(bus.o_mem_address);
  endtask

  task automatic lookup(input logic r0, input logic [31:0] a0,
                        input logic r1, input logic [31:0] a1);
    bus.i_read           = {r1, r0};
    bus.i_req_address[0] = a0;
    bus.i_req_address[1] = a1;
    tick();
    bus.i_read = 2'b00;
  endtask

  // Called in the first FILL cycle; returns in the COMMIT cycle.
  task automatic fill(input logic [31:0] base, input int stall, input int flush_beat);
    for (int b = 0; b < 4; b++) begin
      chk("fill_mem_read", bus.o_mem_read, 1'b1);
      chk("fill_mem_addr", bus.o_mem_address, base + 32'(4 * b));
      if (stall > 0 && b == 1) begin
        bus.i_mem_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          chk("stall_addr_hold", bus.o_mem_address, base + 32'd4);
          chk("stall_mem_read", bus.o_mem_read, 1'b1);
        end
      end
      bus.i_mem_ready = 1'b1;
      bus.i_flush     = (b == flush_beat);
      tick();
      bus.i_mem_ready = 1'b0;
      bus.i_flush     = 1'b0;
    end
    chk("commit_mem_read", bus.o_mem_read, 1'b0);
  endtask

  initial begin
    bus.i_read        = 2'b00;
    bus.i_req_address = '0;
    bus.i_flush       = 1'b0;
    bus.i_mem_ready   = 1'b0;
    bus.i_mem_data    = 32'd0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_hit", bus.o_hit, 2'b00);
    chk("rst_data0", bus.o_data[0], 32'd0);
    chk("rst_resp1", bus.o_resp_address[1], 32'd0);
    chk("rst_mem_read", bus.o_mem_read, 1'b0);
    chk("rst_mem_addr", bus.o_mem_address, 32'd0);
    rst_n = 1'b1;
    tick();

    // Cold miss on 0x100, refill, then hit on the second word
    lookup(1'b1, 32'h100, 1'b0, 32'h0);
    chk("cold_hit0", bus.o_hit[0], 1'b0);
    fill(32'h100, 0, -1);
    tick();
    chk("idle_mem_read", bus.o_mem_read, 1'b0);
    lookup(1'b1, 32'h104, 1'b0, 32'h0);
    chk("rehit0", bus.o_hit[0], 1'b1);
    chk("rehit_data0", bus.o_data[0], mem_word(32'h104));
    chk("rehit_resp0", bus.o_resp_address[0], 32'h104);

    // No request: hit drops, data and address hold
    tick();
    chk("hold_hit0", bus.o_hit[0], 1'b0);
    chk("hold_data0", bus.o_data[0], mem_word(32'h104));
    chk("hold_resp0", bus.o_resp_address[0], 32'h104);

    // Port 1 miss on 0x110
    lookup(1'b0, 32'h0, 1'b1, 32'h110);
    chk("p1_miss_hit1", bus.o_hit[1], 1'b0);
    fill(32'h110, 0, -1);
    tick();

    // Dual hit on different lines, then on the same line
    lookup(1'b1, 32'h108, 1'b1, 32'h110);
    chk("dual_hit", bus.o_hit, 2'b11);
    chk("dual_resp0", bus.o_resp_address[0], 32'h108);
    chk("dual_resp1", bus.o_resp_address[1], 32'h110);
    chk("dual_data0", bus.o_data[0], mem_word(32'h108));
    chk("dual_data1", bus.o_data[1], mem_word(32'h110));
    lookup(1'b1, 32'h10C, 1'b1, 32'h100);
    chk("same_line_hit", bus.o_hit, 2'b11);
    chk("same_line_data1", bus.o_data[1], mem_word(32'h100));

    // Dual miss on different lines: 0x200 then pending 0x300
    lookup(1'b1, 32'h200, 1'b1, 32'h300);
    chk("dmiss_hit", bus.o_hit, 2'b00);
    fill(32'h200, 0, -1);
    tick();
    fill(32'h300, 0, -1);
    tick();
    lookup(1'b1, 32'h204, 1'b1, 32'h308);
    chk("dmiss_both_hit", bus.o_hit, 2'b11);
    chk("dmiss_data0", bus.o_data[0], mem_word(32'h204));
    chk("dmiss_data1", bus.o_data[1], mem_word(32'h308));

    // Dual miss on the same line: single refill only
    lookup(1'b1, 32'h400, 1'b1, 32'h404);
    fill(32'h400, 0, -1);
    tick();
    chk("sameline_no_second", bus.o_mem_read, 1'b0);
    lookup(1'b1, 32'h404, 1'b0, 32'h0);
    chk("sameline_hit", bus.o_hit[0], 1'b1);

    // Stalled memory between beats
    lookup(1'b1, 32'h600, 1'b0, 32'h0);
    fill(32'h600, 3, -1);
    tick();
    lookup(1'b1, 32'h608, 1'b0, 32'h0);
    chk("stall_hit", bus.o_hit[0], 1'b1);
    chk("stall_data", bus.o_data[0], mem_word(32'h608));

    // Flush at beat 2: refill completes but the line stays invalid
    lookup(1'b1, 32'h700, 1'b0, 32'h0);
    fill(32'h700, 0, 2);
    tick();
    lookup(1'b1, 32'h704, 1'b0, 32'h0);
    chk("postflush_hit", bus.o_hit[0], 1'b0);
    chk("postflush_refill", bus.o_mem_read, 1'b1);
    chk("postflush_addr", bus.o_mem_address, 32'h700);
    fill(32'h700, 0, -1);
    tick();
    lookup(1'b1, 32'h70C, 1'b0, 32'h0);
    chk("refilled_hit", bus.o_hit[0], 1'b1);
    chk("refilled_data", bus.o_data[0], mem_word(32'h70C));

    // Flush coincident with a lookup of a valid line
    bus.i_flush = 1'b1;
    lookup(1'b1, 32'h700, 1'b0, 32'h0);
    bus.i_flush = 1'b0;
    chk("flush_lookup_hit", bus.o_hit[0], 1'b0);
    tick();

    // Reset during beat 1 of a refill
    lookup(1'b1, 32'h100, 1'b0, 32'h0);
    fill(32'h100, 0, -1);
    tick();
    lookup(1'b1, 32'h100, 1'b0, 32'h0);
    chk("pre_rst_hit", bus.o_hit[0], 1'b1);
    lookup(1'b1, 32'h800, 1'b0, 32'h0);
    bus.i_mem_ready = 1'b1;
    tick();
    bus.i_mem_ready = 1'b0;
    chk("beat1_addr", bus.o_mem_address, 32'h804);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midfill_rst_mem_read", bus.o_mem_read, 1'b0);
    chk("midfill_rst_hit", bus.o_hit, 2'b00);
    lookup(1'b1, 32'h100, 1'b0, 32'h0);
    chk("post_rst_miss", bus.o_hit[0], 1'b0);
    chk("post_rst_refill", bus.o_mem_read, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
